// File: rtl/fp_pkg.sv
// Shared single-precision constants, accumulator FSM states and the Inf pattern.
package fp_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_MAX  = 255;
  localparam int FP_FRAC_W   = 23;
  localparam int FP_EXP_W    = 8;
  // Hidden one + fraction + one guard bit.
  localparam int FP_MANT_W   = FP_FRAC_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_WRITE
  } fp_acc_state_t;

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Right shifter for exponent alignment; counts >= mantissa width yield zero.
module fp_align_shift
  import fp_pkg::*;
(
  input  logic [FP_MANT_W-1:0] i_mant,
  input  logic [FP_EXP_W-1:0]  i_shamt,
  output logic [FP_MANT_W-1:0] o_mant
);

  // Saturating shift: everything falls off once the difference covers the operand.
  always_comb begin
    if (i_shamt >= FP_EXP_W'(FP_MANT_W)) o_mant = '0;
    else                                 o_mant = i_mant >> i_shamt;
  end

endmodule

// File: rtl/fp_accumulator.sv
// Multi-cycle single-precision accumulator fed by the FP multiplier.
// Build option FP_ACC_ROUND_EN: round half-up on the guard bit in WRITE;
// when undefined the guard bit is truncated. Latency is the same either way.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int NORM_MAX = 25
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_overflow,
  output logic        in_ready,
  output logic [31:0] acc_out,
  output logic        out_valid,
  output logic        overflow,
  output logic        busy
);

  localparam int MW = FP_MANT_W;
  localparam int XW = FP_EXP_W + 2;
  localparam int CW = $clog2(NORM_MAX + 1);
`ifdef FP_ACC_ROUND_EN
  localparam logic RND_EN = 1'b1;
`else
  localparam logic RND_EN = 1'b0;
`endif

  fp_acc_state_t r_state, w_next;
  logic [31:0]   r_acc, r_b;
  logic          r_ovf, r_out_valid, r_skip, r_zero, r_sign;
  logic [MW-1:0] r_ma, r_mb, r_mant;
  logic [XW-1:0] r_exp;
  logic [CW-1:0] r_nsh;

  logic                w_accept, w_skip, w_a_ge, w_same, w_a_gt, w_b_gt;
  logic                w_norm_flush, w_norm_done;
  logic [FP_EXP_W-1:0] w_a_exp, w_b_exp, w_shamt;
  logic [MW-1:0]       w_ma, w_mb, w_sh_in, w_sh_out, w_rnd;
  logic [MW:0]         w_sum;
  logic [XW-1:0]       w_wexp;
  logic [FP_FRAC_W-1:0] w_frac;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = ~in_ready;
  assign acc_out   = r_acc;
  assign out_valid = r_out_valid;
  assign overflow  = r_ovf;

  // clear wins over a simultaneous handshake.
  assign w_accept = in_valid && in_ready && !clear;
  // Inf inputs and an already-saturated sum both bypass the arithmetic.
  assign w_skip   = (in_data[30:23] == 8'hFF) || in_overflow || r_ovf;

  // Alignment: exp==0 means zero, so its mantissa has no hidden one.
  assign w_a_exp = r_acc[30:23];
  assign w_b_exp = r_b[30:23];
  assign w_ma    = (w_a_exp == '0) ? '0 : {1'b1, r_acc[22:0], 1'b0};
  assign w_mb    = (w_b_exp == '0) ? '0 : {1'b1, r_b[22:0], 1'b0};
  assign w_a_ge  = (w_a_exp >= w_b_exp);
  assign w_shamt = w_a_ge ? (w_a_exp - w_b_exp) : (w_b_exp - w_a_exp);
  assign w_sh_in = w_a_ge ? w_mb : w_ma;

  fp_align_shift u_align (
    .i_mant  (w_sh_in),
    .i_shamt (w_shamt),
    .o_mant  (w_sh_out)
  );

  // Add / subtract operands.
  assign w_sum  = {1'b0, r_ma} + {1'b0, r_mb};
  assign w_same = (r_acc[31] == r_b[31]);
  assign w_a_gt = (r_ma > r_mb);
  assign w_b_gt = (r_mb > r_ma);

  // Normalization ends on zero, a set hidden bit, exponent underflow or shift cap.
  assign w_norm_flush = (r_exp <= XW'(1)) || (int'(r_nsh) >= NORM_MAX);
  assign w_norm_done  = (r_mant == '0) || r_mant[MW-1] || w_norm_flush;

  // Rounding on the guard bit; a carry renormalizes by one and bumps the exponent.
  assign w_rnd  = {1'b0, r_mant[MW-1:1]} + MW'(RND_EN & r_mant[0]);
  assign w_wexp = r_exp + XW'(w_rnd[MW-1]);
  assign w_frac = w_rnd[MW-1] ? w_rnd[MW-2:1] : w_rnd[MW-3:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: fixed ALIGN/ADD, data-dependent NORM length, clear aborts.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_skip ? ST_WRITE : ST_ALIGN;
      ST_ALIGN: w_next = ST_ADD;
      ST_ADD:   w_next = ST_NORM;
      ST_NORM:  if (w_norm_done) w_next = ST_WRITE;
      ST_WRITE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (clear) w_next = ST_IDLE;
  end

  // Datapath: one step of the align/add/normalize/write sequence per state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0; r_ovf <= 1'b0; r_out_valid <= 1'b0;
      r_b <= '0; r_skip <= 1'b0; r_zero <= 1'b0; r_sign <= 1'b0;
      r_ma <= '0; r_mb <= '0; r_mant <= '0; r_exp <= '0; r_nsh <= '0;
    end else if (clear) begin
      r_acc <= '0; r_ovf <= 1'b0; r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_b    <= in_data;
          r_skip <= w_skip;
        end
        ST_ALIGN: begin
          r_ma   <= w_a_ge ? w_ma : w_sh_out;
          r_mb   <= w_a_ge ? w_sh_out : w_mb;
          r_exp  <= XW'(w_a_ge ? w_a_exp : w_b_exp);
          r_zero <= 1'b0;
          r_nsh  <= '0;
        end
        ST_ADD: begin
          if (w_same) begin
            r_sign <= r_acc[31];
            if (w_sum[MW]) begin
              r_mant <= w_sum[MW:1];
              r_exp  <= r_exp + XW'(1);
            end else begin
              r_mant <= w_sum[MW-1:0];
            end
          end else if (w_a_gt) begin
            r_sign <= r_acc[31];
            r_mant <= r_ma - r_mb;
          end else if (w_b_gt) begin
            r_sign <= r_b[31];
            r_mant <= r_mb - r_ma;
          end else begin
            r_sign <= 1'b0;
            r_mant <= '0;
          end
        end
        ST_NORM: begin
          if (r_mant == '0) begin
            r_zero <= 1'b1;
          end else if (!r_mant[MW-1]) begin
            if (w_norm_flush) begin
              r_zero <= 1'b1;
            end else begin
              r_mant <= r_mant << 1;
              r_exp  <= r_exp - XW'(1);
              r_nsh  <= r_nsh + CW'(1);
            end
          end
        end
        ST_WRITE: begin
          r_out_valid <= 1'b1;
          if (r_skip) begin
            if (!r_ovf) begin
              r_acc <= fp_inf(r_b[31]);
              r_ovf <= 1'b1;
            end
          end else if (r_zero) begin
            r_acc <= '0;
          end else if (w_wexp >= XW'(FP_EXP_MAX)) begin
            r_acc <= fp_inf(r_sign);
            r_ovf <= 1'b1;
          end else begin
            r_acc <= {r_sign, w_wexp[FP_EXP_W-1:0], w_frac};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential single-precision accumulator that sits directly downstream of the floating-point multiplier. It consumes the multiplier's product and overflow flag over a valid/ready handshake and adds each product into a running IEEE-754-format sum. The result is exposed as a registered accumulator word with a one-cycle completion strobe. It uses a multi-cycle align/add/normalize FSM, so only one product is in flight at a time.

## Interface
- `NORM_MAX`, default 25: maximum left-normalization shifts. Must be ≥ 25.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `clear`, input, 1: synchronous clear. Highest priority after reset.
- `in_valid`, input, 1: `in_data` and `in_overflow` hold a product.
- `in_data`, input, 32: product word `{sign, exp[7:0], frac[22:0]}`.
- `in_overflow`, input, 1: multiplier overflow flag for this product.
- `in_ready`, output, 1: high only in IDLE. Transfer occurs when `in_valid && in_ready` at a rising edge.
- `acc_out`, output, 32: current accumulated sum.
- `out_valid`, output, 1: one-cycle pulse when `acc_out` has just been updated.
- `overflow`, output, 1: sticky overflow. Cleared only by `rst` or `clear`.
- `busy`, output, 1: FSM not in IDLE.

## Operation
- States: IDLE → ALIGN → ADD → NORM → WRITE → IDLE.
- Zero rule: any operand with exp = 0 is zero. Denormals are not supported.
- Inf rule: the input is Inf if exp = 0xFF or `in_overflow` = 1.
  - Inf input, or `overflow` already set: skip to WRITE.
  - `acc_out` becomes `{in_sign, 8'hFF, 23'h0}` and `overflow` is set.
  - Once `overflow` is set, further products are accepted and `acc_out` is unchanged.
- ALIGN: operands are `{1, frac}` with a guard bit appended, giving 25 bits.
  - The operand with the smaller exponent is right-shifted by the exponent difference in one cycle.
  - A difference ≥ 25 makes it 0.
  - The result exponent is the larger exponent.
- ADD:
  - Same signs: add magnitudes into 26 bits. On carry-out, shift right by 1 and increment the exponent.
  - Different signs: subtract the smaller magnitude from the larger. The sign is taken from the larger magnitude.
  - Equal magnitudes give +0 (0x00000000).
- NORM: one state cycle per step.
  - If the mantissa is zero, go to WRITE with result 0.
  - Else if bit 24 = 1, go to WRITE.
  - Else shift left 1 and decrement the exponent.
  - Exponent reaching ≤ 0 flushes the result to 0 and goes to WRITE.
- WRITE: round (see Configuration), then apply range checks.
  - Rounding carry renormalizes and increments the exponent.
  - Exponent ≥ 255: store `{sign, 8'hFF, 23'h0}` and set `overflow`.
  - Otherwise store `{sign, exp[7:0], mant[22:0]}`.
- `clear`:
  - Aborts any operation and forces IDLE.
  - `acc_out` = 0, `overflow` = 0, `out_valid` = 0.
  - A simultaneous handshake is ignored.
- Reset values: `acc_out` = 0, `overflow` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1 (IDLE).

## Timing
- Acceptance at the edge ending cycle T.
- ALIGN at T+1, ADD at T+2, NORM at T+3 … T+3+n, WRITE at T+4+n, where n = number of left shifts (0–24).
- `acc_out` updates and `out_valid` pulses in cycle T+5+n. Minimum latency is 5 cycles; the FSM is back in IDLE in that cycle.
- Inf and sticky-overflow path: T+1 is WRITE; `out_valid` is at T+2.
- `in_ready` is combinational from state: high exactly in IDLE.
- Back-to-back acceptance is legal in the `out_valid` cycle.
- Reset asserted mid-operation returns to IDLE asynchronously, with all outputs at their reset values.

## Configuration
- `FP_ACC_ROUND_EN` defined: round half-up on the guard bit, matching the multiplier's rounding.
- `FP_ACC_ROUND_EN` undefined: truncate; the guard bit is discarded in WRITE.
- Latency is identical in both builds.

## Structure
- Shared package `fp_pkg`:
  - constants `FP_EXP_BIAS` = 127, `FP_EXP_MAX` = 255, `FP_FRAC_W` = 23, `FP_EXP_W` = 8;
  - the `fp_acc_state_t` enum;
  - an Inf-pattern function.
- One sub-module, `fp_align_shift`: a combinational 25-bit right shifter with a saturating shift count, used in ALIGN.

## Test plan
- Accept 0x3F800000, then 0x40000000 → `acc_out` = 0x3F800000 then 0x40400000; each `out_valid` exactly 5 cycles after acceptance.
- Accumulator 0x3FC00000, input 0xBFC00000 → `acc_out` = 0x00000000, `overflow` = 0.
- Accumulator 0x3F800000, input 0xBF7FFFFF → `acc_out` = 0x33800000 with n = 24, so `out_valid` 29 cycles after acceptance.
- 0x7F000000 twice → `acc_out` = 0x7F800000, `overflow` = 1. A later 0x3F800000 leaves both unchanged. `in_overflow` = 1 with 0xFF800000 input from a fresh clear → 0xFF800000.
- Hold `in_valid` continuously with changing data → `in_ready` low during ALIGN–WRITE. Exactly one product is consumed per `out_valid` and none is lost or duplicated.
- Pulse `clear` during NORM → next cycle IDLE, `acc_out` = 0, `overflow` = 0, no `out_valid`. Repeat the same check with asynchronous `rst` asserted mid-ADD.
